// File: rtl/amber_hazard_scoreboard.sv
// Hazard scoreboard for the amber core: tracks in-flight writers, forwards the youngest match
// and stalls on load-use. Define AMBER_HAZARD_PERF_EN to build the stall performance counters.
module amber_hazard_scoreboard #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_DEPTH  = 4,
  parameter int unsigned LOAD_STALL = 3
) (
  input  logic                          iw_clk,
  input  logic                          iw_rst_n,
  input  logic                          iw_flush,
  input  logic                          iw_id_valid,
  input  logic [NUM_SRC-1:0]            iw_id_src_en,
  input  logic [NUM_SRC*ADDR_W-1:0]     iw_id_src_addr,
  input  logic                          iw_id_tgt_en,
  input  logic [ADDR_W-1:0]             iw_id_tgt_addr,
  input  logic                          iw_id_is_load,
  input  logic [FWD_DEPTH*DATA_W-1:0]   iw_stg_result,
  output logic                          ow_stall,
  output logic [NUM_SRC-1:0]            ow_fwd_hit,
  output logic [NUM_SRC*DATA_W-1:0]     ow_fwd_data,
  output logic [15:0]                   ow_stall_events,
  output logic [15:0]                   ow_stall_cycles
);

  localparam int unsigned CntW = (LOAD_STALL > 1) ? $clog2(LOAD_STALL) : 1;

  typedef enum logic [0:0] {StIdle, StStall} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [FWD_DEPTH-1:0] vld_q, load_q;
  logic [ADDR_W-1:0]    addr_q [FWD_DEPTH];
  logic [NUM_SRC-1:0]   found;
  logic                 hazard;
  logic                 stall;
  logic                 issue;

  // Youngest matching stage wins; only a non-ready load in stage 0 raises a stall.
  always_comb begin
    ow_fwd_hit  = '0;
    ow_fwd_data = '0;
    found       = '0;
    hazard      = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      for (int unsigned s = 0; s < FWD_DEPTH; s++) begin
        if (!found[k] && iw_id_src_en[k] && vld_q[s] &&
            (addr_q[s] == iw_id_src_addr[k*ADDR_W +: ADDR_W])) begin
          found[k] = 1'b1;
          if (!load_q[s] || (s >= LOAD_STALL)) begin
            ow_fwd_hit[k]                  = 1'b1;
            ow_fwd_data[k*DATA_W +: DATA_W] = iw_stg_result[s*DATA_W +: DATA_W];
          end else if (s == 0) begin
            hazard = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall = hazard & iw_id_valid;
        // The detection cycle is itself a stall cycle, so STALL covers the remaining ones.
        if (hazard && iw_id_valid && !iw_flush && (LOAD_STALL > 1)) begin
          state_d = StStall;
          cnt_d   = CntW'(LOAD_STALL - 1);
        end
      end
      StStall: begin
        stall = 1'b1;
        cnt_d = cnt_q - CntW'(1);
        if (iw_flush || (cnt_d == '0)) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (iw_flush) begin
      stall = 1'b0;
    end
  end

  assign ow_stall = stall;
  assign issue    = iw_id_valid & iw_id_tgt_en & ~stall & ~iw_flush;

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      vld_q  <= '0;
      load_q <= '0;
      for (int unsigned s = 0; s < FWD_DEPTH; s++) begin
        addr_q[s] <= '0;
      end
    end else begin
      vld_q     <= iw_flush ? '0 : {vld_q[FWD_DEPTH-2:0], issue};
      load_q    <= {load_q[FWD_DEPTH-2:0], iw_id_is_load};
      addr_q[0] <= iw_id_tgt_addr;
      for (int unsigned s = 1; s < FWD_DEPTH; s++) begin
        addr_q[s] <= addr_q[s-1];
      end
    end
  end

`ifdef AMBER_HAZARD_PERF_EN
  logic [15:0] events_q;
  logic [15:0] cycles_q;
  logic        stall_start;

  assign stall_start = (state_q == StIdle) & stall;

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      events_q <= '0;
      cycles_q <= '0;
    end else begin
      if (stall_start && (events_q != 16'hFFFF)) begin
        events_q <= events_q + 16'd1;
      end
      if (stall && (cycles_q != 16'hFFFF)) begin
        cycles_q <= cycles_q + 16'd1;
      end
    end
  end

  assign ow_stall_events = events_q;
  assign ow_stall_cycles = cycles_q;
`else
  assign ow_stall_events = '0;
  assign ow_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_amber_hazard_scoreboard.sv
// Bench for amber_hazard_scoreboard: directed vector table, a reset-mid-stall sequence and
// randomized traffic against a timestamp-based reference model.
module tb_amber_hazard_scoreboard;
  localparam int DW = 24;
  localparam int AW = 4;
  localparam int NS = 2;
  localparam int FD = 4;
  localparam int LS = 3;
`ifdef AMBER_HAZARD_PERF_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              id_valid = 1'b0;
  logic [NS-1:0]     src_en = '0;
  logic [NS*AW-1:0]  src_addr = '0;
  logic              tgt_en = 1'b0;
  logic [AW-1:0]     tgt_addr = '0;
  logic              is_load = 1'b0;
  logic [FD*DW-1:0]  stg_result = '0;
  logic              stall;
  logic [NS-1:0]     fwd_hit;
  logic [NS*DW-1:0]  fwd_data;
  logic [15:0]       ev_cnt;
  logic [15:0]       cy_cnt;

  amber_hazard_scoreboard #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .NUM_SRC   (NS),
    .FWD_DEPTH (FD),
    .LOAD_STALL(LS)
  ) dut (
    .iw_clk         (clk),
    .iw_rst_n       (rst_n),
    .iw_flush       (flush),
    .iw_id_valid    (id_valid),
    .iw_id_src_en   (src_en),
    .iw_id_src_addr (src_addr),
    .iw_id_tgt_en   (tgt_en),
    .iw_id_tgt_addr (tgt_addr),
    .iw_id_is_load  (is_load),
    .iw_stg_result  (stg_result),
    .ow_stall       (stall),
    .ow_fwd_hit     (fwd_hit),
    .ow_fwd_data    (fwd_data),
    .ow_stall_events(ev_cnt),
    .ow_stall_cycles(cy_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // flush valid sen s0 s1 ten tgt ld | r0 r1 r2 r3 | stall hit d0 d1 | ev cy (perf build)
  typedef struct {
    int flush; int valid; int sen; int s0; int s1; int ten; int tgt; int ld;
    int r0; int r1; int r2; int r3;
    int stall; int hit; int d0; int d1; int ev; int cy;
  } vec_t;

  typedef struct {
    int           cyc;
    logic [AW-1:0] addr;
    bit           load;
  } iss_t;

  function automatic logic [63:0] perf_exp(input int v);
    return Perf ? 64'(v) : 64'd0;
  endfunction

  initial begin
    vec_t vecs[$];
    iss_t hist[$];
    int   stall_left;
    int   m_ev;
    int   m_cy;
    logic [NS-1:0]    exp_hit;
    logic [NS*DW-1:0] exp_data;
    bit   hz;
    bit   exp_stall;
    int   age;

    vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,  0,0,0,0,          0,0,0,0,        0,0});
    vecs.push_back(vec_t'{0,1,0,0,0,1,1,0,  0,0,0,0,          0,0,0,0,        0,0});
    vecs.push_back(vec_t'{0,1,1,1,0,0,0,0,  12,0,0,0,         0,1,12,0,       0,0});
    vecs.push_back(vec_t'{0,1,0,0,0,1,3,0,  0,0,0,0,          0,0,0,0,        0,0});
    vecs.push_back(vec_t'{0,1,0,0,0,0,0,0,  0,0,0,0,          0,0,0,0,        0,0});
    vecs.push_back(vec_t'{0,1,0,0,0,1,3,0,  0,0,0,0,          0,0,0,0,        0,0});
    vecs.push_back(vec_t'{0,1,3,3,1,0,0,0,  16,0,9,0,         0,1,16,0,       0,0});
    vecs.push_back(vec_t'{0,1,2,0,3,0,0,0,  0,'h55,0,'h66,    0,2,0,'h55,     0,0});
    vecs.push_back(vec_t'{0,1,0,0,0,1,5,1,  0,0,0,0,          0,0,0,0,        0,0});
    vecs.push_back(vec_t'{0,1,1,5,0,1,7,0,  0,0,0,0,          1,0,0,0,        0,0});
    vecs.push_back(vec_t'{0,1,1,5,0,1,7,0,  0,0,0,0,          1,0,0,0,        1,1});
    vecs.push_back(vec_t'{0,1,1,5,0,1,7,0,  0,0,0,0,          1,0,0,0,        1,2});
    vecs.push_back(vec_t'{0,1,1,5,0,1,7,0,  0,0,0,'h12,       0,1,'h12,0,     1,3});
    vecs.push_back(vec_t'{0,1,0,0,0,1,5,1,  0,0,0,0,          0,0,0,0,        1,3});
    vecs.push_back(vec_t'{0,1,0,0,0,0,0,0,  0,0,0,0,          0,0,0,0,        1,3});
    vecs.push_back(vec_t'{0,1,1,5,0,0,0,0,  0,0,0,0,          0,0,0,0,        1,3});
    vecs.push_back(vec_t'{0,1,1,5,0,0,0,0,  0,0,0,0,          0,0,0,0,        1,3});
    vecs.push_back(vec_t'{0,1,1,5,0,0,0,0,  0,0,0,'h34,       0,1,'h34,0,     1,3});
    vecs.push_back(vec_t'{0,1,0,0,0,1,6,1,  0,0,0,0,          0,0,0,0,        1,3});
    vecs.push_back(vec_t'{0,1,1,6,0,1,8,0,  0,0,0,0,          1,0,0,0,        1,3});
    vecs.push_back(vec_t'{1,1,1,6,0,1,8,0,  0,0,0,0,          0,0,0,0,        2,4});
    vecs.push_back(vec_t'{0,1,3,6,6,0,0,0,  0,0,'hAA,'hBB,    0,0,0,0,        2,4});
    vecs.push_back(vec_t'{0,1,3,6,6,0,0,0,  0,0,'hAA,'hBB,    0,0,0,0,        2,4});
    vecs.push_back(vec_t'{0,1,0,0,0,1,9,1,  0,0,0,0,          0,0,0,0,        2,4});
    vecs.push_back(vec_t'{0,1,2,9,2,0,0,0,  0,0,0,0,          0,0,0,0,        2,4});
    vecs.push_back(vec_t'{0,1,0,0,0,1,10,1, 0,0,0,0,          0,0,0,0,        2,4});
    vecs.push_back(vec_t'{0,1,1,10,0,0,0,0, 0,0,0,0,          1,0,0,0,        2,4});
    vecs.push_back(vec_t'{0,1,1,10,0,0,0,0, 0,0,0,0,          1,0,0,0,        3,5});
    vecs.push_back(vec_t'{0,1,1,10,0,0,0,0, 0,0,0,0,          1,0,0,0,        3,6});
    vecs.push_back(vec_t'{0,1,1,10,0,1,11,1,0,0,0,'h77,       0,1,'h77,0,     3,7});
    vecs.push_back(vec_t'{0,1,1,11,0,0,0,0, 0,0,0,0,          1,0,0,0,        3,7});

    // Reset state while reset is held.
    #3;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_hit", 64'(fwd_hit), 64'd0);
    check("rst_data", 64'(fwd_data), 64'd0);
    check("rst_events", 64'(ev_cnt), 64'd0);
    check("rst_cycles", 64'(cy_cnt), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      flush      = vecs[i].flush[0];
      id_valid   = vecs[i].valid[0];
      src_en     = NS'(vecs[i].sen);
      src_addr   = {AW'(vecs[i].s1), AW'(vecs[i].s0)};
      tgt_en     = vecs[i].ten[0];
      tgt_addr   = AW'(vecs[i].tgt);
      is_load    = vecs[i].ld[0];
      stg_result = {DW'(vecs[i].r3), DW'(vecs[i].r2), DW'(vecs[i].r1), DW'(vecs[i].r0)};
      #4;
      check($sformatf("vec%0d_stall", i), 64'(stall), 64'(vecs[i].stall));
      check($sformatf("vec%0d_hit", i), 64'(fwd_hit), 64'(vecs[i].hit));
      check($sformatf("vec%0d_d0", i), 64'(fwd_data[0 +: DW]), 64'(vecs[i].d0));
      check($sformatf("vec%0d_d1", i), 64'(fwd_data[DW +: DW]), 64'(vecs[i].d1));
      check($sformatf("vec%0d_events", i), 64'(ev_cnt), perf_exp(vecs[i].ev));
      check($sformatf("vec%0d_cycles", i), 64'(cy_cnt), perf_exp(vecs[i].cy));
      @(posedge clk);
      #1;
    end

    // Last vector left a load-use stall in progress; reset must drop it at once.
    check("midstall_stall", 64'(stall), 64'd1);
    check("midstall_events", 64'(ev_cnt), perf_exp(4));
    check("midstall_cycles", 64'(cy_cnt), perf_exp(8));
    rst_n = 1'b0;
    #1;
    check("async_rst_stall", 64'(stall), 64'd0);
    check("async_rst_hit", 64'(fwd_hit), 64'd0);
    check("async_rst_events", 64'(ev_cnt), 64'd0);
    check("async_rst_cycles", 64'(cy_cnt), 64'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    id_valid = 1'b0;
    src_en   = '0;
    tgt_en   = 1'b0;
    is_load  = 1'b0;
    rst_n    = 1'b1;
    #4;
    check("post_rst_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;

    stall_left = 0;
    m_ev       = 0;
    m_cy       = 0;
    for (int t = 0; t < 600; t++) begin
      flush      = ($urandom_range(99) < 5);
      id_valid   = ($urandom_range(99) < 85);
      src_en     = NS'($urandom_range(3));
      src_addr   = {AW'($urandom_range(3)), AW'($urandom_range(3))};
      tgt_en     = ($urandom_range(99) < 60);
      tgt_addr   = AW'($urandom_range(3));
      is_load    = ($urandom_range(99) < 40);
      stg_result = {$urandom(), $urandom(), $urandom()};

      // Each issued writer sits at stage (now - issue_cycle - 1) until it leaves the window.
      while (hist.size() > 0 && (t - hist[0].cyc - 1) >= FD) void'(hist.pop_front());
      exp_hit  = '0;
      exp_data = '0;
      hz       = 1'b0;
      for (int k = 0; k < NS; k++) begin
        if (src_en[k]) begin
          for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i].addr == src_addr[k*AW +: AW]) begin
              age = t - hist[i].cyc - 1;
              if (!hist[i].load || age >= LS) begin
                exp_hit[k]              = 1'b1;
                exp_data[k*DW +: DW]    = stg_result[age*DW +: DW];
              end else if (age == 0) begin
                hz = 1'b1;
              end
              break;
            end
          end
        end
      end
      exp_stall = !flush && (stall_left > 0 || (hz && id_valid));

      #4;
      check("rnd_stall", 64'(stall), 64'(exp_stall));
      check("rnd_hit", 64'(fwd_hit), 64'(exp_hit));
      check("rnd_data", 64'(fwd_data), 64'(exp_data));
      check("rnd_events", 64'(ev_cnt), perf_exp(m_ev));
      check("rnd_cycles", 64'(cy_cnt), perf_exp(m_cy));

      if (exp_stall && stall_left == 0 && m_ev < 65535) m_ev++;
      if (exp_stall && m_cy < 65535) m_cy++;
      if (flush) stall_left = 0;
      else if (stall_left > 0) stall_left--;
      else if (hz && id_valid) stall_left = LS - 1;
      if (flush) hist.delete();
      else if (id_valid && tgt_en && !exp_stall) hist.push_back(iss_t'{t, tgt_addr, is_load});

      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
